// File: rtl/mem_port_arbiter6.sv
// Round-robin arbiter for one shared memory port with six requesters.
// Holds each grant until port_resp (or watchdog expiry), then rotates priority.
module mem_port_arbiter6 #(
  parameter int NREQ    = 6,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            port_resp,
  output logic [2:0]      sel,
  output logic [NREQ-1:0] grant,
  output logic            port_req,
  output logic [NREQ-1:0] done,
  output logic            timeout_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sel_reg, sel_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic            timeout_err_reg, timeout_err_next;

  logic [2:0]      cand [NREQ];
  logic [2:0]      winner;
  logic            winner_vld;
  logic            wd_expire;
  logic [2:0]      ptr_after;

  // cand[k] is the requester index examined k-th, starting from ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [3:0] sum;
    assign sum      = {1'b0, ptr_reg} + 4'(gi);
    assign cand[gi] = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
  end

  always_comb begin
    winner     = 3'd0;
    winner_vld = 1'b0;
    // Walk from the lowest-priority end so the highest-priority hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner     = cand[k];
        winner_vld = 1'b1;
      end
    end
  end

  if (TIMEOUT != 0) begin : g_wd
    assign wd_expire = (count_reg == CNTW'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign wd_expire = 1'b0;
  end

  assign ptr_after = (sel_reg == 3'd5) ? 3'd0 : sel_reg + 3'd1;

  always_comb begin
    state_next       = state_reg;
    sel_next         = sel_reg;
    ptr_next         = ptr_reg;
    grant_next       = grant_reg;
    count_next       = count_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (winner_vld) begin
          state_next = S_GRANT;
          sel_next   = winner;
          grant_next = NREQ'(1) << winner;
          count_next = '0;
        end
      end
      S_GRANT: begin
        if (port_resp || wd_expire) begin
          state_next = S_RELEASE;
          grant_next = '0;
          ptr_next   = ptr_after;
          // A response arriving on the expiry cycle is a normal completion.
          if (!port_resp) timeout_err_next = 1'b1;
        end else if (count_reg != '1) begin
          count_next = count_reg + 1'b1;
        end
      end
      S_RELEASE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      sel_reg         <= 3'd0;
      ptr_reg         <= 3'd0;
      grant_reg       <= '0;
      count_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sel_reg         <= sel_next;
      ptr_reg         <= ptr_next;
      grant_reg       <= grant_next;
      count_reg       <= count_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign sel         = sel_reg;
  assign grant       = grant_reg;
  assign port_req    = (state_reg == S_GRANT);
  assign busy        = (state_reg == S_GRANT) || (state_reg == S_RELEASE);
  assign done        = grant_reg & {NREQ{port_resp}};
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter6.sv
// Directed bench for mem_port_arbiter6 (TIMEOUT=8); inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_port_arbiter6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] req = 6'd0;
  logic       port_resp = 1'b0;
  logic [2:0] sel;
  logic [5:0] grant;
  logic       port_req;
  logic [5:0] done;
  logic       timeout_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter6 #(.NREQ(6), .TIMEOUT(8), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .port_resp(port_resp),
    .sel(sel), .grant(grant), .port_req(port_req), .done(done),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 6'd0; port_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sel, grant, port_req, busy, timeout_err, done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset: sel=%0d grant=%b port_req=%b busy=%b terr=%b done=%b, want all 0",
               sel, grant, port_req, busy, timeout_err, done);
    end
    rst_n = 1'b1;
    $display("txn reset checked");
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 6'b000100;
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'b000100 || sel !== 3'd2 || port_req !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b sel=%0d port_req=%b busy=%b, want 000100/2/1/1",
               grant, sel, port_req, busy);
    end
    @(negedge clk);
    @(negedge clk);
    port_resp = 1'b1;
    #1;
    n_cmp++;
    if (done !== 6'b000100) begin
      n_bad++;
      $display("FAIL single_done: done=%b, want 000100", done);
    end
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    #1;
    n_cmp++;
    if (grant !== 6'd0 || port_req !== 1'b0 || busy !== 1'b1 || done !== 6'd0 || sel !== 3'd2) begin
      n_bad++;
      $display("FAIL single_release: grant=%b port_req=%b busy=%b done=%b sel=%0d, want 0/0/1/0/2",
               grant, port_req, busy, done, sel);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || sel !== 3'd2) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b sel=%0d, want 0/2", busy, sel);
    end
    // Pointer is now 3: an all-ones request must go to requester 3.
    req = 6'b111111;
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'b001000 || sel !== 3'd3) begin
      n_bad++;
      $display("FAIL ptr_after_single: grant=%b sel=%0d, want 001000/3", grant, sel);
    end
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    $display("txn single req=000100 checked");
  endtask

  task automatic test_round_robin();
    logic [5:0] want;
    do_reset();
    req = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      want = 6'd1 << (k % 6);
      @(negedge clk);
      n_cmp++;
      if (grant !== want || sel !== 3'(k % 6)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: grant=%b sel=%0d, want %b/%0d", k, grant, sel, want, k % 6);
      end
      @(negedge clk);
      port_resp = 1'b1;
      #1;
      n_cmp++;
      if (done !== want) begin
        n_bad++;
        $display("FAIL rr_done%0d: done=%b, want %b", k, done, want);
      end
      @(negedge clk);
      port_resp = 1'b0;
      n_cmp++;
      if (grant !== 6'd0 || port_req !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_release%0d: grant=%b port_req=%b, want 0/0", k, grant, port_req);
      end
      @(negedge clk);
      $display("txn rr grant %0d checked", k % 6);
    end
    req = 6'd0;
    @(negedge clk);
  endtask

  task automatic test_wrap_scan();
    // Pointer is 1 here; grant 3 to move it to 4.
    req = 6'b001000;
    @(negedge clk);
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    req = 6'b000011;
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'b000001 || sel !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_scan: grant=%b sel=%0d, want 000001/0", grant, sel);
    end
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'b000010 || sel !== 3'd1) begin
      n_bad++;
      $display("FAIL wrap_next_ptr: grant=%b sel=%0d, want 000010/1", grant, sel);
    end
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    $display("txn wrap scan req=000011 checked");
  endtask

  task automatic test_timeout();
    req = 6'b010000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (grant !== 6'b010000 || timeout_err !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_hold%0d: grant=%b terr=%b, want 010000/0", c, grant, timeout_err);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'd0 || timeout_err !== 1'b1 || port_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_fire: grant=%b terr=%b port_req=%b, want 0/1/0",
               grant, timeout_err, port_req);
    end
    req = 6'b000001;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (grant !== 6'b000001 || timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_after: grant=%b terr=%b, want 000001/1", grant, timeout_err);
    end
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    $display("txn timeout req=010000 checked");
  endtask

  task automatic test_resp_at_limit();
    do_reset();
    req = 6'b000010;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    port_resp = 1'b1;
    #1;
    n_cmp++;
    if (done !== 6'b000010) begin
      n_bad++;
      $display("FAIL limit_done: done=%b, want 000010", done);
    end
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL limit_terr: terr=%b busy=%b, want 0/0", timeout_err, busy);
    end
    $display("txn resp at timeout limit checked");
  endtask

  task automatic test_reset_mid_grant();
    req = 6'b000100;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 6'd0 || sel !== 3'd0 || port_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: grant=%b sel=%0d port_req=%b busy=%b, want 0/0/0/0",
               grant, sel, port_req, busy);
    end
    req = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 6'b100000;
    @(negedge clk);
    n_cmp++;
    if (sel !== 3'd5 || grant !== 6'b100000) begin
      n_bad++;
      $display("FAIL post_reset_grant: sel=%0d grant=%b, want 5/100000", sel, grant);
    end
    port_resp = 1'b1;
    @(negedge clk);
    port_resp = 1'b0; req = 6'd0;
    @(negedge clk);
    port_resp = 1'b1;
    #1;
    n_cmp++;
    if (done !== 6'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_resp: done=%b busy=%b, want 0/0", done, busy);
    end
    @(negedge clk);
    port_resp = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || grant !== 6'd0 || sel !== 3'd5) begin
      n_bad++;
      $display("FAIL idle_resp_state: busy=%b grant=%b sel=%0d, want 0/0/5", busy, grant, sel);
    end
    $display("txn reset mid-grant checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_scan();
    test_timeout();
    test_resp_at_limit();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
